stencil3d_sched: RTL and testbench
==================================

# stencil3d_sched

Sequencer for the 7-point 3D stencil datapath. It walks every interior point of a ROW_SIZE×COL_SIZE×HEIGHT_SIZE grid and fetches the centre and six neighbours from the `orig` memory through a valid/ready read port with in-order responses. For each point it computes `C0*centre + C1*(sum of six neighbours)` and writes the result to the `sol` memory through a valid/ready write port. It replaces the fully unrolled single-cycle stencil with a memory-backed, one-point-at-a-time engine.

## Interface
- ROW_SIZE, 16, extent of innermost index k
- COL_SIZE, 32, extent of middle index j
- HEIGHT_SIZE, 32, extent of outer index i
- ADDR_W, 14, memory address width; must satisfy 2^ADDR_W ≥ ROW_SIZE*COL_SIZE*HEIGHT_SIZE
- DATA_W, 32, data and coefficient width
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE
- C0, C1  in  DATA_W  coefficients; latched into internal registers on accepted start
- busy  out  1  high from the cycle after start is accepted until the cycle done is asserted
- done  out  1  one-cycle pulse after the last write is accepted
- rd_req_valid / rd_req_ready  out / in  1  read-request handshake
- rd_addr  out  ADDR_W  read address
- rd_rsp_valid  in  1  read data valid; responses return in request order, latency ≥ 1
- rd_rsp_data  in  DATA_W  read data
- wr_valid / wr_ready  out / in  1  write handshake
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  write data

## Operation
- **Addressing:** idx(k,j,i) = k + ROW_SIZE*(j + COL_SIZE*i).
- **Sweep order:** i is outermost over 1..HEIGHT_SIZE-2, then j over 1..COL_SIZE-2, then k innermost over 1..ROW_SIZE-2. Boundary points are never read-centred and never written.
- **FSM states:** IDLE → RUN → CALC → WRITE → (RUN on next point | DONE) → IDLE.
- **IDLE:** on start=1, latch C0/C1, set i=j=k=1, clear counters, go to RUN.
- **RUN, issue side:**
  - Issue counter q (0..7) steps through the read order: centre, (i+1), (i-1), (j+1), (j-1), (k+1), (k-1).
  - rd_req_valid=1 while q<7.
  - q increments when rd_req_valid && rd_req_ready.
  - rd_addr must stay stable while valid is high and ready is low.
- **RUN, response side:**
  - Response counter r (0..7) counts rd_rsp_valid.
  - r==0 loads the centre register.
  - r=1..6 accumulate into the neighbour sum.
  - Responses arriving while issuing is still in progress are accepted.
- **RUN exit:** when r reaches 7, go to CALC. The 7th response and the transition may coincide.
- **CALC (1 cycle):** wr_data_reg = centre*C0 + nsum*C1. All arithmetic is unsigned and modulo 2^DATA_W; the neighbour sum wraps at DATA_W bits.
- **WRITE:**
  - wr_valid=1, wr_addr=idx(k,j,i); wr_addr and wr_data are held stable until wr_ready.
  - On acceptance, advance k, carrying into j, then into i.
  - If the point just written was the last interior point, go to DONE; otherwise go to RUN with q=r=0.
- **DONE (1 cycle):** done=1, busy=0, then IDLE.
- **Ignored inputs:**
  - start is ignored outside IDLE.
  - rd_rsp_valid is ignored in IDLE, CALC, WRITE and DONE.
  - rd_rsp_valid is ignored in RUN once r==7.
- **Reset:** all outputs are driven to 0 (busy, done, rd_req_valid, rd_addr, wr_valid, wr_addr, wr_data). The FSM returns to IDLE and counters, indices and coefficient registers clear. Reset mid-sweep abandons the sweep; no done is produced.

## Timing
- start accepted at edge T → busy=1 and rd_req_valid=1 from T+1.
- Per point with ready tied high and response latency L:
  - 7 issue cycles, last response at issue+6+L;
  - +1 CALC cycle, +1 WRITE cycle.
  - Total 9+L cycles per point.
- Full sweep with defaults: 30*30*14 = 12600 points. At L=1 this is 126000 cycles from start to the last write; done follows one cycle after the last write handshake.
- No read for the next point is issued before the current write is accepted; there is no overlap between points.

## Test plan
- **Constant grid:** ROW=COL=HEIGHT=4, orig all 1, C0=2, C1=3, ready high, L=1 → exactly 8 writes, each data 20, at addresses 21,22,25,26,37,38,41,42 in that order, then done pulse.
- **Ramp grid:** same size, orig[n]=n, C0=C1=1 → each write data = 7*addr, first write (21, 147).
- **Backpressure:** random rd_req_ready, wr_ready and response latency 1–5 → identical write sequence to the ramp grid case; rd_addr, wr_addr and wr_data stable while stalled.
- **Overflow wrap:** orig all 0xFFFFFFFF, C0=1, C1=1 → each write 0xFFFFFFF9.
- **Start while busy:** start pulsed mid-sweep → ignored, write count unchanged, single done; a spurious rd_rsp_valid in IDLE has no effect.
- **Reset mid-sweep:** rst_n low after the 3rd write → all outputs 0 next cycle, no done; a new start gives a full correct sweep from address 21.

Source files
------------

// File: rtl/stencil3d_sched.sv
// 7-point 3D stencil sequencer: fetches centre + six neighbours per interior point over a
// valid/ready read port (in-order responses) and writes C0*centre + C1*sum, one point at a time.
module stencil3d_sched #(
  parameter int ROW_SIZE    = 16,
  parameter int COL_SIZE    = 32,
  parameter int HEIGHT_SIZE = 32,
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] C0,
  input  logic [DATA_W-1:0] C1,
  output logic              busy,
  output logic              done,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_rsp_valid,
  input  logic [DATA_W-1:0] rd_rsp_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);
  localparam int KW = $clog2(ROW_SIZE);
  localparam int JW = $clog2(COL_SIZE);
  localparam int IW = $clog2(HEIGHT_SIZE);
  localparam logic [KW-1:0] K_LAST = KW'(ROW_SIZE - 2);
  localparam logic [JW-1:0] J_LAST = JW'(COL_SIZE - 2);
  localparam logic [IW-1:0] I_LAST = IW'(HEIGHT_SIZE - 2);
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(ROW_SIZE);
  localparam logic [ADDR_W-1:0] PLANE_STEP = ADDR_W'(ROW_SIZE * COL_SIZE);

  typedef enum logic [2:0] {IDLE, RUN, CALC, WRITE, DONE} state_t;

  state_t            state, state_n;
  logic [KW-1:0]     k;
  logic [JW-1:0]     j;
  logic [IW-1:0]     i;
  logic [2:0]        q, r;
  logic [DATA_W-1:0] c0_reg, c1_reg, centre, nsum, wr_data_reg;
  logic [ADDR_W-1:0] centre_addr, nb_addr;
  logic              last_pt;

  assign centre_addr = ADDR_W'(k) + ROW_STEP * (ADDR_W'(j) + ADDR_W'(COL_SIZE) * ADDR_W'(i));
  assign last_pt     = (k == K_LAST) && (j == J_LAST) && (i == I_LAST);

  // Read order: centre, i+1, i-1, j+1, j-1, k+1, k-1
  always_comb begin
    nb_addr = centre_addr;
    case (q)
      3'd1:    nb_addr = centre_addr + PLANE_STEP;
      3'd2:    nb_addr = centre_addr - PLANE_STEP;
      3'd3:    nb_addr = centre_addr + ROW_STEP;
      3'd4:    nb_addr = centre_addr - ROW_STEP;
      3'd5:    nb_addr = centre_addr + ADDR_W'(1);
      3'd6:    nb_addr = centre_addr - ADDR_W'(1);
      default: nb_addr = centre_addr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n      = state;
    busy         = 1'b0;
    done         = 1'b0;
    rd_req_valid = 1'b0;
    wr_valid     = 1'b0;
    case (state)
      IDLE: if (start) state_n = RUN;
      RUN: begin
        busy         = 1'b1;
        rd_req_valid = (q != 3'd7);
        // The 7th response may land in the same cycle we leave for CALC
        if (r == 3'd7 || (r == 3'd6 && rd_rsp_valid)) state_n = CALC;
      end
      CALC: begin
        busy    = 1'b1;
        state_n = WRITE;
      end
      WRITE: begin
        busy     = 1'b1;
        wr_valid = 1'b1;
        if (wr_ready) state_n = last_pt ? DONE : RUN;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign rd_addr = rd_req_valid ? nb_addr : '0;
  assign wr_addr = wr_valid ? centre_addr : '0;
  assign wr_data = wr_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0; j <= '0; i <= '0; q <= '0; r <= '0;
      c0_reg <= '0; c1_reg <= '0; centre <= '0; nsum <= '0; wr_data_reg <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          c0_reg <= C0;
          c1_reg <= C1;
          k <= KW'(1); j <= JW'(1); i <= IW'(1);
          q <= '0; r <= '0; nsum <= '0;
        end
        RUN: begin
          if (rd_req_valid && rd_req_ready) q <= q + 3'd1;
          if (rd_rsp_valid && r != 3'd7) begin
            if (r == 3'd0) centre <= rd_rsp_data;
            else           nsum   <= nsum + rd_rsp_data;
            r <= r + 3'd1;
          end
        end
        CALC: wr_data_reg <= centre * c0_reg + nsum * c1_reg;
        WRITE: if (wr_ready) begin
          q <= '0; r <= '0; nsum <= '0;
          if (k == K_LAST) begin
            k <= KW'(1);
            if (j == J_LAST) begin
              j <= JW'(1);
              i <= i + IW'(1);
            end else begin
              j <= j + JW'(1);
            end
          end else begin
            k <= k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_stencil3d_sched.sv
// Bench for stencil3d_sched on a 4x4x4 grid: memory/responder model, scoreboard of expected
// reads and writes computed from the grid contents, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_stencil3d_sched;
  localparam int R = 4, C = 4, H = 4, AW = 6, DW = 32;
  localparam int NPTS = (R-2)*(C-2)*(H-2);

  logic clk, rst_n, start, busy, done;
  logic [DW-1:0] c0, c1;
  logic rd_req_valid, rd_req_ready, rd_rsp_valid, wr_valid, wr_ready;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_rsp_data, wr_data;

  stencil3d_sched #(.ROW_SIZE(R), .COL_SIZE(C), .HEIGHT_SIZE(H), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .C0(c0), .C1(c1), .busy(busy), .done(done),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data));

  typedef struct {int due; logic [DW-1:0] d;} rsp_t;
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;

  logic [DW-1:0] mem [0:R*C*H-1];
  rsp_t          pend[$];
  wr_t           exp_wr[$];
  logic [AW-1:0] exp_rd[$];
  logic [AW-1:0] obs_a[$];
  logic [DW-1:0] obs_d[$];
  logic [AW-1:0] const_addrs [8];

  int nchk, nerr, nwr, ndone, cyc, last_wr_edge, start_edge, last_due;
  bit bp, inj;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(string name, longint unsigned act, longint unsigned expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Expected reads and writes, straight from the stencil definition over the current grid
  task automatic build_model(input logic [DW-1:0] c0v, input logic [DW-1:0] c1v);
    exp_wr.delete();
    exp_rd.delete();
    for (int i = 1; i <= H-2; i++)
      for (int j = 1; j <= C-2; j++)
        for (int k = 1; k <= R-2; k++) begin
          int ctr;
          logic [DW-1:0] s, v;
          ctr = k + R*(j + C*i);
          exp_rd.push_back(AW'(ctr));
          exp_rd.push_back(AW'(ctr + R*C));
          exp_rd.push_back(AW'(ctr - R*C));
          exp_rd.push_back(AW'(ctr + R));
          exp_rd.push_back(AW'(ctr - R));
          exp_rd.push_back(AW'(ctr + 1));
          exp_rd.push_back(AW'(ctr - 1));
          s = mem[ctr+R*C] + mem[ctr-R*C] + mem[ctr+R] + mem[ctr-R] + mem[ctr+1] + mem[ctr-1];
          v = mem[ctr]*c0v + s*c1v;
          exp_wr.push_back('{a: AW'(ctr), d: v});
        end
  endtask

  // Memory responder, ready generator and compare process
  initial begin : env
    int m, lat, due_v;
    bit prs, pws;
    logic [AW-1:0] pra, pwa;
    logic [DW-1:0] pwd;
    wr_t e;
    rd_req_ready = 1'b0; wr_ready = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_data = '0;
    prs = 0; pws = 0; pra = '0; pwa = '0; pwd = '0; last_due = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend.delete();
        last_due = 0;
        rd_rsp_valid = 1'b0; rd_req_ready = 1'b0; wr_ready = 1'b0;
        prs = 0; pws = 0;
      end else begin
        m = cyc + 1;
        if (prs) begin
          check("rd_valid_hold", rd_req_valid, 1);
          check("rd_addr_hold", rd_addr, pra);
        end
        if (pws) begin
          check("wr_valid_hold", wr_valid, 1);
          check("wr_addr_hold", wr_addr, pwa);
          check("wr_data_hold", wr_data, pwd);
        end
        if (pend.size() > 0 && pend[0].due <= m) begin
          rd_rsp_valid = 1'b1;
          rd_rsp_data  = pend[0].d;
          pend.delete(0);
        end else if (inj && !busy) begin
          rd_rsp_valid = 1'b1;
          rd_rsp_data  = 32'h0BAD_F00D;
        end else begin
          rd_rsp_valid = 1'b0;
        end
        rd_req_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        wr_ready     = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rd_req_valid && rd_req_ready) begin
          check("rd_expected", exp_rd.size() > 0, 1);
          if (exp_rd.size() > 0) check("rd_addr", rd_addr, exp_rd.pop_front());
          lat   = bp ? int'($urandom_range(1, 5)) : 1;
          due_v = m + lat;
          if (due_v <= last_due) due_v = last_due + 1;
          last_due = due_v;
          pend.push_back('{due: due_v, d: mem[rd_addr]});
        end
        if (wr_valid) check("no_read_during_write", rd_req_valid, 0);
        if (wr_valid && wr_ready) begin
          check("wr_expected", exp_wr.size() > 0, 1);
          if (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            check("wr_addr", wr_addr, e.a);
            check("wr_data", wr_data, e.d);
          end
          obs_a.push_back(wr_addr);
          obs_d.push_back(wr_data);
          nwr++;
          last_wr_edge = m;
        end
        if (done) begin
          ndone++;
          check("done_timing", cyc, last_wr_edge);
          check("done_all_written", exp_wr.size(), 0);
          check("busy_low_in_done", busy, 0);
        end
        prs = rd_req_valid && !rd_req_ready;
        pra = rd_addr;
        pws = wr_valid && !wr_ready;
        pwa = wr_addr;
        pwd = wr_data;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_edge = cyc;
  endtask

  task automatic wait_done(int budget);
    int n0;
    n0 = ndone;
    for (int t = 0; t < budget && ndone == n0; t++) @(negedge clk);
    check("done_seen", ndone > n0, 1);
  endtask

  task automatic clear_obs();
    nwr = 0; ndone = 0;
    obs_a.delete(); obs_d.delete();
  endtask

  task automatic run_sweep(input logic [DW-1:0] c0v, input logic [DW-1:0] c1v);
    c0 = c0v; c1 = c1v;
    build_model(c0v, c1v);
    clear_obs();
    @(negedge clk);
    pulse_start();
    check("busy_after_start", busy, 1);
    check("rd_valid_after_start", rd_req_valid, 1);
    wait_done(4000);
    repeat (3) @(negedge clk);
    check("write_count", nwr, NPTS);
    check("done_count", ndone, 1);
    check("reads_left", exp_rd.size(), 0);
  endtask

  task automatic fill(input int mode);
    for (int n = 0; n < R*C*H; n++)
      mem[n] = (mode == 0) ? 32'd1 : (mode == 1) ? DW'(n) : 32'hFFFF_FFFF;
  endtask

  initial begin : main
    nchk = 0; nerr = 0; nwr = 0; ndone = 0; last_wr_edge = 0; start_edge = 0;
    bp = 0; inj = 0;
    rst_n = 1'b0; start = 1'b0; c0 = '0; c1 = '0;
    const_addrs = '{6'd21, 6'd22, 6'd25, 6'd26, 6'd37, 6'd38, 6'd41, 6'd42};
    fill(0);
    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy, done, rd_req_valid, wr_valid}, 0);
    check("rst_addr", {rd_addr, wr_addr}, 0);
    check("rst_data", wr_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Constant grid
    fill(0);
    run_sweep(2, 3);
    check("const_count", obs_a.size(), 8);
    for (int p = 0; p < obs_a.size() && p < 8; p++) begin
      check("const_addr", obs_a[p], const_addrs[p]);
      check("const_data", obs_d[p], 20);
    end
    check("sweep_cycles", last_wr_edge - start_edge, 80);

    // Ramp grid
    fill(1);
    run_sweep(1, 1);
    check("ramp_first_addr", obs_a.size() > 0 ? obs_a[0] : 0, 21);
    check("ramp_first_data", obs_d.size() > 0 ? obs_d[0] : 0, 147);
    for (int p = 0; p < obs_a.size(); p++) check("ramp_7x", obs_d[p], 7 * obs_a[p]);

    // Backpressure on both ports with variable latency
    bp = 1;
    run_sweep(1, 1);
    bp = 0;
    check("bp_first_data", obs_d.size() > 0 ? obs_d[0] : 0, 147);
    check("bp_last_addr", obs_a.size() == 8 ? obs_a[7] : 0, 42);

    // Overflow wrap
    fill(2);
    run_sweep(1, 1);
    check("wrap_first", obs_d.size() > 0 ? obs_d[0] : 0, 32'hFFFF_FFF9);
    check("wrap_last", obs_d.size() == 8 ? obs_d[7] : 0, 32'hFFFF_FFF9);

    // Start while busy, then stray responses while idle
    fill(1);
    c0 = 1; c1 = 1;
    build_model(1, 1);
    clear_obs();
    @(negedge clk);
    pulse_start();
    repeat (25) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(4000);
    repeat (3) @(negedge clk);
    check("restart_write_count", nwr, NPTS);
    check("restart_done_count", ndone, 1);
    inj = 1;
    repeat (10) @(negedge clk);
    check("idle_no_read", rd_req_valid, 0);
    check("idle_not_busy", busy, 0);
    inj = 0;
    @(negedge clk);
    run_sweep(1, 1);
    check("post_stray_first_data", obs_d.size() > 0 ? obs_d[0] : 0, 147);

    // Reset mid-sweep
    build_model(1, 1);
    clear_obs();
    @(negedge clk);
    pulse_start();
    for (int t = 0; t < 2000 && nwr < 3; t++) @(negedge clk);
    check("three_writes", nwr, 3);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ctrl", {busy, done, rd_req_valid, wr_valid}, 0);
    check("midrst_addr", {rd_addr, wr_addr}, 0);
    check("midrst_data", wr_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_done_after_reset", ndone, 0);
    run_sweep(1, 1);
    check("after_reset_first_addr", obs_a.size() > 0 ? obs_a[0] : 0, 21);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
